// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: FSM encoding, default widths
// and token field offsets used by the downstream packer.
package rle_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } rle_state_e;

    localparam int unsigned RleDataW = 32;
    localparam int unsigned RleCntW  = 8;

    // Packed token layout at default widths: {sym, count, last}
    localparam int unsigned TokLastLsb = 0;
    localparam int unsigned TokCntLsb  = 1;
    localparam int unsigned TokSymLsb  = 1 + RleCntW;
    localparam int unsigned TokW       = 1 + RleCntW + RleDataW;

endpackage

// File: rtl/rle_tok_reg.sv
// Single-entry token holding register; contents stay stable while valid and stalled,
// and a same-cycle drain plus reload is allowed.
module rle_tok_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] sym_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] sym_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              last_o,
    output logic              free_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] sym_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;

    assign free_o = ~valid_q | ready_i;

    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                sym_q  <= sym_i;
                cnt_q  <= cnt_i;
                last_q <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign sym_o   = sym_q;
    assign cnt_o   = cnt_q;
    assign last_o  = last_q;

endmodule

// File: rtl/rle_enc_stream.sv
// Streaming run-length encoder: words in, {symbol, count, last} tokens out.
// Define RLE_STATS_EN to add accept/drain counters with a synchronous clear.
module rle_enc_stream
    import rle_pkg::*;
#(
    parameter int unsigned DATA_W  = RleDataW,
    parameter int unsigned CNT_W   = RleCntW,
    parameter int unsigned MAX_RUN = (1 << CNT_W) - 1
) (
    input  logic              clock,
    input  logic              sysres,
`ifdef RLE_STATS_EN
    input  logic              stat_clr,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_tokens,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sym,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] MaxRunC = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    rle_state_e        state_q, state_d;
    logic [DATA_W-1:0] cur_sym_q, sym_d;
    logic [CNT_W-1:0]  cur_cnt_q, cnt_d;

    logic              tok_load, tok_last, tok_free;
    logic [DATA_W-1:0] tok_sym;
    logic [CNT_W-1:0]  tok_cnt;
    logic              accept;

    assign in_ready = (state_q != StFlush) & tok_free;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        sym_d    = cur_sym_q;
        cnt_d    = cur_cnt_q;
        tok_load = 1'b0;
        tok_sym  = cur_sym_q;
        tok_cnt  = cur_cnt_q;
        tok_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sym_d = in_data;
                    cnt_d = CntOne;
                    if (in_last) begin
                        tok_load = 1'b1;
                        tok_sym  = in_data;
                        tok_cnt  = CntOne;
                        tok_last = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    if ((in_data == cur_sym_q) && (cur_cnt_q < MaxRunC)) begin
                        cnt_d = cur_cnt_q + CntOne;
                        if (in_last) begin
                            tok_load = 1'b1;
                            tok_cnt  = cur_cnt_q + CntOne;
                            tok_last = 1'b1;
                            cnt_d    = '0;
                            state_d  = StIdle;
                        end
                    end else begin
                        // Close the old run; a flagged word must wait for its own token slot
                        tok_load = 1'b1;
                        sym_d    = in_data;
                        cnt_d    = CntOne;
                        if (in_last) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                if (tok_free) begin
                    tok_load = 1'b1;
                    tok_last = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge sysres) begin
        if (!sysres) begin
            state_q   <= StIdle;
            cur_sym_q <= '0;
            cur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sym_q <= sym_d;
            cur_cnt_q <= cnt_d;
        end
    end

    rle_tok_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_tok_reg (
        .clk_i   (clock),
        .rst_ni  (sysres),
        .load_i  (tok_load),
        .sym_i   (tok_sym),
        .cnt_i   (tok_cnt),
        .last_i  (tok_last),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .sym_o   (out_sym),
        .cnt_o   (out_count),
        .last_o  (out_last),
        .free_o  (tok_free)
    );

`ifdef RLE_STATS_EN
    logic [31:0] stat_words_q, stat_tokens_q;

    always_ff @(posedge clock or negedge sysres) begin
        if (!sysres) begin
            stat_words_q  <= '0;
            stat_tokens_q <= '0;
        end else if (stat_clr) begin
            stat_words_q  <= '0;
            stat_tokens_q <= '0;
        end else begin
            if (accept) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (out_valid && out_ready) begin
                stat_tokens_q <= stat_tokens_q + 32'd1;
            end
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_tokens = stat_tokens_q;
`endif

endmodule

// File: tb/tb_rle_enc_stream.sv
// Directed bench for rle_enc_stream: per-cycle vector table on a default and a
// CNT_W=2 instance, plus backpressure and asynchronous-reset sequences.
module tb_rle_enc_stream;

    logic        clock = 1'b0;
    logic        sysres;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [31:0] in_data, out_sym;
    logic [7:0]  out_count;

    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_last;
    logic [31:0] s_in_data, s_out_sym;
    logic [1:0]  s_out_count;

`ifdef RLE_STATS_EN
    logic        stat_clr, s_stat_clr;
    logic [31:0] stat_words, stat_tokens, s_stat_words, s_stat_tokens;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    rle_enc_stream dut (
        .clock       (clock),
        .sysres      (sysres),
`ifdef RLE_STATS_EN
        .stat_clr    (stat_clr),
        .stat_words  (stat_words),
        .stat_tokens (stat_tokens),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sym     (out_sym),
        .out_count   (out_count),
        .out_last    (out_last)
    );

    rle_enc_stream #(.CNT_W(2)) dut_sat (
        .clock       (clock),
        .sysres      (sysres),
`ifdef RLE_STATS_EN
        .stat_clr    (s_stat_clr),
        .stat_words  (s_stat_words),
        .stat_tokens (s_stat_tokens),
`endif
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .in_data     (s_in_data),
        .in_last     (s_in_last),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready),
        .out_sym     (s_out_sym),
        .out_count   (s_out_count),
        .out_last    (s_out_last)
    );

    typedef struct {
        bit          sat;
        bit          v;
        logic [31:0] data;
        bit          last;
        bit          ordy;
        bit          e_irdy;
        bit          e_ov;
        logic [31:0] e_sym;
        int          e_cnt;
        bit          e_last;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit sat, bit v, logic [31:0] d, bit last, bit ordy,
                                bit e_irdy, bit e_ov, logic [31:0] e_sym, int e_cnt,
                                bit e_last);
        vec_t r;
        r.sat = sat;  r.v = v;  r.data = d;  r.last = last;  r.ordy = ordy;
        r.e_irdy = e_irdy;  r.e_ov = e_ov;  r.e_sym = e_sym;  r.e_cnt = e_cnt;
        r.e_last = e_last;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: in_ready checked before the edge, token outputs after it.
    task automatic apply(input vec_t r, input string tag);
        if (r.sat) begin
            s_in_valid = r.v;  s_in_data = r.data;  s_in_last = r.last;  s_out_ready = r.ordy;
            in_valid = 1'b0;   in_data = '0;        in_last = 1'b0;      out_ready = 1'b1;
        end else begin
            in_valid = r.v;    in_data = r.data;    in_last = r.last;    out_ready = r.ordy;
            s_in_valid = 1'b0; s_in_data = '0;      s_in_last = 1'b0;    s_out_ready = 1'b1;
        end
        #1;
        check({tag, " in_ready"}, r.sat ? s_in_ready : in_ready, r.e_irdy);
        @(posedge clock);
        #1;
        check({tag, " out_valid"}, r.sat ? s_out_valid : out_valid, r.e_ov);
        if (r.e_ov) begin
            check({tag, " out_sym"}, r.sat ? s_out_sym : out_sym, r.e_sym);
            check({tag, " out_count"}, r.sat ? 64'(s_out_count) : 64'(out_count), r.e_cnt);
            check({tag, " out_last"}, r.sat ? s_out_last : out_last, r.e_last);
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end
    endtask

    // Basic-runs stream under a 10-cycle output stall, checked by token scoreboard.
    task automatic run_backpressure();
        logic [31:0] sw[13];
        bit          sl[13];
        logic [31:0] exp_sym[4];
        int          exp_cnt[4];
        bit          exp_last[4];
        logic [31:0] tsym[$];
        int          tcnt[$];
        bit          tlast[$];
        int          idx = 0, cyc = 0, low_seen = 0;
        bit          hold = 1'b0, acc, hl;
        logic [31:0] hs;
        logic [7:0]  hc;
        for (int i = 0; i < 13; i++) begin
            sw[i] = (i < 5) ? 32'hDEADBEEF : (i < 8) ? 32'hFFFFFFFF :
                    (i < 12) ? 32'hCCCCCCCC : 32'hA0A0A0A0;
            sl[i] = (i == 12);
        end
        exp_sym  = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hCCCCCCCC, 32'hA0A0A0A0};
        exp_cnt  = '{5, 3, 4, 1};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        while ((idx < 13 || tsym.size() < 4) && cyc < 200) begin
            in_valid  = (idx < 13);
            in_data   = (idx < 13) ? sw[idx] : '0;
            in_last   = (idx < 13) ? sl[idx] : 1'b0;
            out_ready = !(cyc >= 5 && cyc < 15);
            #1;
            if (hold) begin
                check($sformatf("bp hold valid c%0d", cyc), out_valid, 1'b1);
                check($sformatf("bp hold sym c%0d", cyc), out_sym, hs);
                check($sformatf("bp hold count c%0d", cyc), out_count, hc);
                check($sformatf("bp hold last c%0d", cyc), out_last, hl);
            end
            if (in_valid && !in_ready) low_seen++;
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                tsym.push_back(out_sym);
                tcnt.push_back(int'(out_count));
                tlast.push_back(out_last);
            end
            hold = out_valid & ~out_ready;
            hs = out_sym;  hc = out_count;  hl = out_last;
            @(posedge clock);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp in_ready dropped", low_seen > 0, 1'b1);
        check("bp words accepted", idx, 13);
        check("bp token count", tsym.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < tsym.size()) begin
                check($sformatf("bp tok%0d sym", i), tsym[i], exp_sym[i]);
                check($sformatf("bp tok%0d count", i), tcnt[i], exp_cnt[i]);
                check($sformatf("bp tok%0d last", i), tlast[i], exp_last[i]);
            end
        end
        @(posedge clock);
        #1;
    endtask

    int nb;

    initial begin
        sysres = 1'b0;
        in_valid = 1'b0;   in_data = '0;   in_last = 1'b0;   out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
`ifdef RLE_STATS_EN
        stat_clr = 1'b0;
        s_stat_clr = 1'b0;
`endif

        // Basic runs
        for (int i = 0; i < 5; i++) vq.push_back(mk(0, 1, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 1, 1, 1, 32'hDEADBEEF, 5, 0));
        for (int i = 0; i < 2; i++) vq.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'hCCCCCCCC, 0, 1, 1, 1, 32'hFFFFFFFF, 3, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 1, 32'hCCCCCCCC, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'hA0A0A0A0, 1, 1, 1, 1, 32'hCCCCCCCC, 4, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 1, 32'hA0A0A0A0, 1, 1));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0));
        nb = vq.size();
        // FLUSH path
        vq.push_back(mk(0, 1, 32'hAAAAAAAA, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'hAAAAAAAA, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'hBBBBBBBB, 1, 1, 1, 1, 32'hAAAAAAAA, 2, 0));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 0, 1, 32'hBBBBBBBB, 1, 1));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0));
        // Single-word packet straight from IDLE
        vq.push_back(mk(0, 1, 32'h55, 1, 1, 1, 1, 32'h55, 1, 1));
        vq.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0));
        // Saturation on the CNT_W=2 instance
        for (int i = 0; i < 3; i++) vq.push_back(mk(1, 1, 32'h11, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 32'h11, 0, 1, 1, 1, 32'h11, 3, 0));
        for (int i = 0; i < 2; i++) vq.push_back(mk(1, 1, 32'h11, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 1, 32'h11, 1, 1, 1, 1, 32'h11, 3, 0));
        vq.push_back(mk(1, 0, 32'h0, 0, 1, 0, 1, 32'h11, 1, 1));
        vq.push_back(mk(1, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0));

        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_sym", out_sym, 32'h0);
        check("reset out_count", out_count, 8'h0);
        check("reset out_last", out_last, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        repeat (3) @(posedge clock);
        #2;
        sysres = 1'b1;

        run_table(0, nb);
`ifdef RLE_STATS_EN
        check("stat_words", stat_words, 32'd13);
        check("stat_tokens", stat_tokens, 32'd4);
        stat_clr = 1'b1;
        apply(mk(0, 1, 32'h77, 1, 1, 1, 1, 32'h77, 1, 1), "clr");
        check("stat_words clr", stat_words, 32'd0);
        check("stat_tokens clr", stat_tokens, 32'd0);
        stat_clr = 1'b0;
        apply(mk(0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0), "clr idle");
`endif
        run_table(nb, vq.size());

        run_backpressure();

        // Reset mid-run with a token held in the output register
        for (int i = 0; i < 3; i++) apply(mk(0, 1, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0, 0), "rst pre");
        apply(mk(0, 1, 32'hCCCCCCCC, 0, 1, 1, 1, 32'hDEADBEEF, 3, 0), "rst pre tok");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        sysres = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 1'b0);
        check("async rst out_sym", out_sym, 32'h0);
        check("async rst out_count", out_count, 8'h0);
        repeat (2) @(posedge clock);
        #2;
        sysres = 1'b1;
        apply(mk(0, 1, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0, 0), "rst post0");
        apply(mk(0, 1, 32'hFFFFFFFF, 1, 1, 1, 1, 32'hFFFFFFFF, 2, 1), "rst post1");
        apply(mk(0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0), "rst post2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_enc_stream.md
Name: rle_enc_stream

Overview:
- Parametrised run-length encoder; successor to the fixed 32-bit RLE block.
- Accepts a stream of DATA_W-bit words over a valid/ready handshake and emits {symbol, run count} tokens over a second valid/ready handshake.
- Adds configurable widths, run saturation, end-of-packet flush and backpressure, none of which the previous generation had.
- Sits between the capture front-end and the packer/storage stage.

Parameters:
- DATA_W, 32, symbol width in bits (>=1).
- CNT_W, 8, run-count field width in bits (>=1).
- MAX_RUN, 2**CNT_W-1, longest run per token; legal range 1..2**CNT_W-1.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- sysres  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  DATA_W  input symbol.
- in_last  in  1  word ends the packet; closes the current run.
- out_valid  out  1  token present.
- out_ready  in  1  downstream accepts the token.
- out_sym  out  DATA_W  token symbol.
- out_count  out  CNT_W  token run length, 1..MAX_RUN; never 0.
- out_last  out  1  token is the final token of the packet.

Behaviour:
- Definitions:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - Internal state: cur_sym, cur_cnt, and the FSM in one of IDLE (no open run), RUN (run open), FLUSH (final token waiting for the output register).
- Reset (sysres=0, asynchronous): FSM=IDLE, cur_cnt=0, cur_sym=0, out_valid=0, out_sym=0, out_count=0, out_last=0. Any partial run is discarded.
- in_ready = (state!=FLUSH) & (!out_valid | out_ready). Same-cycle drain and reload of the output register is legal.
- Transitions:
  - IDLE + accept: cur_sym=in_data, cur_cnt=1 -> RUN. If in_last is also set, emit (in_data,1,last=1) -> IDLE.
  - RUN + accept, in_data==cur_sym and cur_cnt<MAX_RUN: cur_cnt+1.
  - RUN + accept, mismatch or cur_cnt==MAX_RUN: emit (cur_sym,cur_cnt,last=0); cur_sym=in_data, cur_cnt=1.
  - Accept with in_last, no token emitted this cycle (matched increment): emit the updated run with last=1 -> IDLE.
  - Accept with in_last, a token already emitted this cycle (mismatch/saturation): -> FLUSH holding the new run; in FLUSH, once the output register is free, emit (cur_sym,cur_cnt,last=1) -> IDLE.
- Latency: a token appears on out_* on the cycle after the accept that closes its run.
- Output stability: out_sym, out_count and out_last are held stable while out_valid & !out_ready.
- Saturation: a run longer than MAX_RUN splits into consecutive tokens of MAX_RUN plus a remainder. No counter wrap-around is permitted.
- Idle gaps: in_valid=0 cycles never close a run. Only a mismatch, saturation or in_last closes one.
- Both handshakes use the standard rule: valid must not depend on ready.

Optional Feature:
- Macro: RLE_STATS_EN.
- When defined:
  - Adds output stat_words (32 bit): counts accepts.
  - Adds output stat_tokens (32 bit): counts drains.
  - Adds input stat_clr: synchronous clear to 0; wins over a same-cycle increment.
  - Both counters wrap at 2**32 and reset to 0.
- When undefined: these ports and counters are absent; the core behaviour is identical.

Decomposition:
- Package rle_pkg holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2).
  - Default DATA_W and CNT_W constants.
  - Token field-offset constants used by the packer.
- Sub-module rle_tok_reg: single-entry output holding register with the valid/ready logic. The encoder core instantiates it once.

Test Plan:
- Basic runs: 5x DEADBEEF, 3x FFFFFFFF, 4x CCCCCCCC, then A0A0A0A0 with in_last, out_ready=1 -> tokens (DEADBEEF,5,0), (FFFFFFFF,3,0), (CCCCCCCC,4,0), (A0A0A0A0,1,1).
- Saturation: CNT_W=2, 7x 00000011 with the last word flagged -> (11,3,0), (11,3,0), (11,1,1). out_count is never 0.
- FLUSH path: AAAAAAAA, AAAAAAAA, then BBBBBBBB with in_last -> (AAAAAAAA,2,0) then (BBBBBBBB,1,1). in_ready is low for the FLUSH cycle.
- Backpressure: basic-runs stimulus with out_ready=0 for 10 cycles mid-stream -> in_ready drops, out_* held stable, same 4 tokens, none lost or duplicated.
- Reset mid-run: 3x DEADBEEF, assert sysres=0 asynchronously for 2 cycles, then 2x FFFFFFFF with in_last -> out_valid=0 immediately; only (FFFFFFFF,2,1) is emitted.
- RLE_STATS_EN: basic-runs stimulus -> stat_words=13, stat_tokens=4. Pulse stat_clr -> both 0 the next cycle.
